// File: rtl/rx_axis_pkg.sv
// Shared types, constants and helpers for the receive bad-frame filter.
package rx_axis_pkg;

  typedef struct packed {
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
  } word_t;

  localparam logic [7:0] LEGAL_KEEP [8] = '{8'h01, 8'h03, 8'h07, 8'h0F,
                                            8'h1F, 8'h3F, 8'h7F, 8'hFF};

  typedef enum logic [2:0] {NONE, OVF, TKEEP, CRC, RUNT} drop_reason_t;

  typedef enum logic {ST_ACCEPT, ST_DROP} in_state_t;

  function automatic logic keep_legal(input logic [7:0] keep);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (keep == LEGAL_KEEP[i]) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, keep[i]};
    end
    return n;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rx_axis_sdpram.sv
// Frame buffer: simple dual-port RAM, synchronous write, asynchronous read.
module rx_axis_sdpram
  import rx_axis_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_axis_bad_frame_drop.sv
// Store-and-forward receive filter: only whole good frames reach m_axis.
// Frame statistics counters are built only when RX_DROP_STATS_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_ACCEPT | beats are written into the buffer and checked
// ST_DROP   | frame already lost to overflow; beats ignored until tlast
module rx_axis_bad_frame_drop
  import rx_axis_pkg::*;
#(
  parameter int AW        = 9,
  parameter int MIN_BYTES = 60
) (
  input  logic        clk,
  input  logic        rx_axis_aresetn,
  input  logic [63:0] rx_axis_tdata,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tvalid,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] stat_good,
  output logic [31:0] stat_crc_bad,
  output logic [31:0] stat_runt,
  output logic [31:0] stat_ovf,
  output logic [31:0] stat_tkeep_bad
);

  localparam int            PW      = AW + 1;
  localparam logic [PW-1:0] DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [15:0]   MIN_CNT = 16'(MIN_BYTES);

  in_state_t     state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] commit_ptr, commit_ptr_nxt;
  logic [PW-1:0] rd_ptr;
  logic [15:0]   byte_cnt, byte_cnt_nxt;
  logic          flag_ovf, flag_ovf_nxt;
  logic          flag_keep, flag_keep_nxt;
  logic          we;
  drop_reason_t  reason;

  logic          full, empty, keep_ok, load;
  logic [16:0]   cnt_sum;
  logic [15:0]   cnt_sat;
  word_t         wr_word, rd_word;

  assign full    = (wr_ptr - rd_ptr) == DEPTH;
  assign empty   = (rd_ptr == commit_ptr);
  assign keep_ok = keep_legal(rx_axis_tkeep) && (rx_axis_tlast || rx_axis_tkeep == 8'hFF);
  assign cnt_sum = {1'b0, byte_cnt} + {13'd0, keep_bytes(rx_axis_tkeep)};
  assign cnt_sat = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  assign wr_word = {rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata};

  rx_axis_sdpram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_word),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      state      <= ST_ACCEPT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      byte_cnt   <= '0;
      flag_ovf   <= 1'b0;
      flag_keep  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      byte_cnt   <= byte_cnt_nxt;
      flag_ovf   <= flag_ovf_nxt;
      flag_keep  <= flag_keep_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    byte_cnt_nxt   = byte_cnt;
    flag_ovf_nxt   = flag_ovf;
    flag_keep_nxt  = flag_keep;
    we             = 1'b0;
    reason         = NONE;
    if (rx_axis_tvalid) begin
      if (state == ST_ACCEPT) begin
        if (full) begin
          flag_ovf_nxt = 1'b1;
          if (!rx_axis_tlast) state_nxt = ST_DROP;
        end else begin
          we           = 1'b1;
          wr_ptr_nxt   = wr_ptr + 1'b1;
          byte_cnt_nxt = cnt_sat;
        end
        if (!keep_ok) flag_keep_nxt = 1'b1;
      end
      // Verdict uses flags and count updated with the tlast beat itself.
      if (rx_axis_tlast) begin
        if (flag_ovf_nxt)                reason = OVF;
        else if (flag_keep_nxt)          reason = TKEEP;
        else if (!rx_axis_tuser)         reason = CRC;
        else if (byte_cnt_nxt < MIN_CNT) reason = RUNT;
        else                             reason = NONE;
        if (reason == NONE) commit_ptr_nxt = wr_ptr_nxt;
        else                wr_ptr_nxt     = commit_ptr;
        state_nxt     = ST_ACCEPT;
        byte_cnt_nxt  = '0;
        flag_ovf_nxt  = 1'b0;
        flag_keep_nxt = 1'b0;
      end
    end
  end

  assign load = !empty && (!m_axis_tvalid || m_axis_tready);

  always_ff @(posedge clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      rd_ptr        <= rd_ptr + 1'b1;
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= rd_word.tdata;
      m_axis_tkeep  <= rd_word.tkeep;
      m_axis_tlast  <= rd_word.tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef RX_DROP_STATS_EN
  always_ff @(posedge clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      stat_good      <= '0;
      stat_crc_bad   <= '0;
      stat_runt      <= '0;
      stat_ovf       <= '0;
      stat_tkeep_bad <= '0;
    end else if (rx_axis_tvalid && rx_axis_tlast) begin
      case (reason)
        NONE:    stat_good      <= sat_inc32(stat_good);
        OVF:     stat_ovf       <= sat_inc32(stat_ovf);
        TKEEP:   stat_tkeep_bad <= sat_inc32(stat_tkeep_bad);
        CRC:     stat_crc_bad   <= sat_inc32(stat_crc_bad);
        RUNT:    stat_runt      <= sat_inc32(stat_runt);
        default: ;
      endcase
    end
  end
`else
  assign stat_good      = '0;
  assign stat_crc_bad   = '0;
  assign stat_runt      = '0;
  assign stat_ovf       = '0;
  assign stat_tkeep_bad = '0;
`endif

endmodule

// File: tb/tb_rx_axis_bad_frame_drop.sv
// Scoreboard bench for rx_axis_bad_frame_drop with a frame-level reference model.
module tb_rx_axis_bad_frame_drop;

  localparam int AW        = 4;
  localparam int DEPTH     = 1 << AW;
  localparam int MIN_BYTES = 60;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] rx_tdata = '0;
  logic [7:0]  rx_tkeep = '0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tlast = 1'b0;
  logic        rx_tuser = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [31:0] stat_good, stat_crc_bad, stat_runt, stat_ovf, stat_tkeep_bad;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tready_mode = 1;
  int rise_cyc = -1;
  int tlast_cyc = 0;
  int n_good = 0, n_crc = 0, n_runt = 0, n_ovf = 0, n_keep = 0;

  beat_t       exp_q[$];
  logic [63:0] frm_d[$];
  logic [7:0]  frm_k[$];

  rx_axis_bad_frame_drop #(.AW(AW), .MIN_BYTES(MIN_BYTES)) dut (
    .clk             (clk),
    .rx_axis_aresetn (rst_n),
    .rx_axis_tdata   (rx_tdata),
    .rx_axis_tkeep   (rx_tkeep),
    .rx_axis_tvalid  (rx_tvalid),
    .rx_axis_tlast   (rx_tlast),
    .rx_axis_tuser   (rx_tuser),
    .m_axis_tdata    (m_tdata),
    .m_axis_tkeep    (m_tkeep),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tlast    (m_tlast),
    .m_axis_tready   (m_tready),
    .stat_good       (stat_good),
    .stat_crc_bad    (stat_crc_bad),
    .stat_runt       (stat_runt),
    .stat_ovf        (stat_ovf),
    .stat_tkeep_bad  (stat_tkeep_bad)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold stability.
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [72:0] held = '0;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (m_tvalid && !prev_valid) rise_cyc = cyc;
      if (prev_stall) chk("stall hold", {m_tlast, m_tkeep, m_tdata}, held);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected beat: got %0h expected none", {m_tlast, m_tkeep, m_tdata});
        end else begin
          e = exp_q.pop_front();
          chk("out beat", {m_tlast, m_tkeep, m_tdata}, {e.l, e.k, e.d});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_valid = m_tvalid;
      held       = {m_tlast, m_tkeep, m_tdata};
    end
  end

  // Frame-level model: classify the whole frame, enqueue it only if good.
  task automatic model_frame(input logic tuser, input bit force_ovf);
    int          bytes;
    bit          kbad;
    logic [7:0]  kp;
    beat_t       b;
    bytes = 0;
    kbad  = 0;
    foreach (frm_k[i]) begin
      bytes += $countones(frm_k[i]);
      kp = frm_k[i] + 8'd1;
      if (frm_k[i] == 8'h00 || (frm_k[i] & kp) != 8'h00) kbad = 1;
      if (i != frm_k.size() - 1 && frm_k[i] != 8'hFF) kbad = 1;
    end
    if (force_ovf || frm_k.size() > DEPTH) n_ovf++;
    else if (kbad)                           n_keep++;
    else if (!tuser)                         n_crc++;
    else if (bytes < MIN_BYTES)              n_runt++;
    else begin
      n_good++;
      foreach (frm_d[i]) begin
        b.d = frm_d[i];
        b.k = frm_k[i];
        b.l = (i == frm_d.size() - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic make_frame(input int n, input logic [7:0] last_k, input int mid_idx,
                            input logic [7:0] mid_k);
    frm_d.delete();
    frm_k.delete();
    for (int i = 0; i < n; i++) begin
      frm_d.push_back({$urandom, $urandom});
      if (i == n - 1)        frm_k.push_back(last_k);
      else if (i == mid_idx) frm_k.push_back(mid_k);
      else                   frm_k.push_back(8'hFF);
    end
  endtask

  // Called and returns at posedge+1; frames issued in sequence are back-to-back.
  task automatic send_frame(input logic tuser, input bit force_ovf);
    model_frame(tuser, force_ovf);
    for (int i = 0; i < frm_d.size(); i++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = frm_d[i];
      rx_tkeep  = frm_k[i];
      rx_tlast  = (i == frm_d.size() - 1);
      rx_tuser  = rx_tlast ? tuser : 1'($urandom_range(0, 1));
      if (rx_tlast) tlast_cyc = cyc;
      @(posedge clk);
      #1;
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || m_tvalid) && i < 400) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({tag, " drain"}, 128'(exp_q.size()), 128'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_stats(input string tag);
    int eg, ec, er, eo, ek;
`ifdef RX_DROP_STATS_EN
    eg = n_good; ec = n_crc; er = n_runt; eo = n_ovf; ek = n_keep;
`else
    eg = 0; ec = 0; er = 0; eo = 0; ek = 0;
`endif
    chk({tag, " stat_good"},      128'(stat_good),      128'(eg));
    chk({tag, " stat_crc_bad"},   128'(stat_crc_bad),   128'(ec));
    chk({tag, " stat_runt"},      128'(stat_runt),      128'(er));
    chk({tag, " stat_ovf"},       128'(stat_ovf),       128'(eo));
    chk({tag, " stat_tkeep_bad"}, 128'(stat_tkeep_bad), 128'(ek));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] lk;
    logic [7:0] mk;
    int midx;

    repeat (3) @(posedge clk);
    #1;
    chk("reset tvalid", 128'(m_tvalid), 128'd0);
    chk("reset tdata", {m_tlast, m_tkeep, m_tdata}, 128'd0);
    check_stats("reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 64-byte good frame and output latency.
    tready_mode = 1;
    rise_cyc = -1;
    make_frame(8, 8'hFF, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    wait_drain("good64");
    chk("first valid latency", 128'(rise_cyc - tlast_cyc), 128'd2);
    check_stats("good64");

    // Good, 100-byte bad CRC, good, back-to-back.
    make_frame(8, 8'hFF, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    make_frame(13, 8'h0F, -1, 8'hFF);
    send_frame(1'b0, 1'b0);
    make_frame(9, 8'h07, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    wait_drain("crc");
    check_stats("crc");

    // Runts around the minimum length, then exactly 60 bytes.
    make_frame(7, 8'hFF, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    make_frame(8, 8'h07, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    make_frame(1, 8'hFF, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    make_frame(8, 8'h0F, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    wait_drain("runt");
    check_stats("runt");

    // Middle beat with partial tkeep; illegal last tkeep.
    make_frame(9, 8'hFF, 4, 8'h0F);
    send_frame(1'b1, 1'b0);
    make_frame(9, 8'h0B, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    wait_drain("tkeep");
    check_stats("tkeep");

    // Fill the buffer with tready low, then overflow the next frame.
    tready_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    make_frame(DEPTH, 8'hFF, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    make_frame(8, 8'hFF, -1, 8'hFF);
    send_frame(1'b1, 1'b1);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    tready_mode = 1;
    wait_drain("ovf");
    make_frame(10, 8'h3F, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    wait_drain("after ovf");
    check_stats("ovf");

    // Randomized frames under random backpressure.
    tready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 19);
      lk = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : (8'hFF >> $urandom_range(0, 7));
      midx = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 17) : -1;
      mk = 8'($urandom_range(1, 255));
      make_frame(n, lk, midx, mk);
      send_frame(1'($urandom_range(0, 4) != 0), 1'b0);
      wait_drain("random");
    end
    check_stats("random");

    // Reset in the middle of output.
    make_frame(8, 8'hFF, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    make_frame(12, 8'hFF, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst tvalid", 128'(m_tvalid), 128'd0);
    chk("midrst tdata", {m_tlast, m_tkeep, m_tdata}, 128'd0);
    chk("midrst stat_good", 128'(stat_good), 128'd0);
    exp_q.delete();
    n_good = 0; n_crc = 0; n_runt = 0; n_ovf = 0; n_keep = 0;
    check_stats("midrst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    make_frame(11, 8'h1F, -1, 8'hFF);
    send_frame(1'b1, 1'b0);
    wait_drain("post reset");
    check_stats("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
